wb_commit_scheduler: RTL

Write-back scheduler for the 32x32 register file's single write port. Shares the port between two producers, the ALU path (A) and the load/long-latency path (B), through valid/ready handshakes and a one-stage registered commit. Tracks in-flight destination registers in a busy scoreboard so issue logic can stall on RAW hazards. Sits between the execute/memory units and the register file's `write_en`/`w_addr`/`w_data` inputs.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_arb2.sv | 54 +++++
 rtl/wb_commit_scheduler.sv | 95 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Optional feature macro: WB_ROUND_ROBIN_EN (round-robin arbitration on contention).
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    // Source IDs double as bit positions in the arbiter request/grant vectors.
    localparam logic WB_SRC_A = 1'b0;
    localparam logic WB_SRC_B = 1'b1;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              src;
    } wb_commit_t;

endpackage

// File: rtl/wb_arb2.sv
// Two-requester arbiter: bit 0 = ALU path (A), bit 1 = load path (B).
// WB_ROUND_ROBIN_EN defined: alternate on contention; otherwise B has fixed priority.
module wb_arb2
    import wb_pkg::*;
(
`ifdef WB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef WB_ROUND_ROBIN_EN
    // ptr_q names the source that wins the next contended cycle (0 = A).
    logic ptr_q;
    logic ptr_d;

    // Grant selection; the pointer only moves when both sources compete.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt   = (ptr_q == WB_SRC_B) ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= WB_SRC_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: loads are never held off by a stream of ALU results.
    always_comb begin
        gnt = 2'b00;
        if (req[WB_SRC_B]) begin
            gnt = 2'b10;
        end else if (req[WB_SRC_A]) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/wb_commit_scheduler.sv
// Write-back scheduler for the register file's single write port: arbitrates
// producers A and B, registers the accepted write for one cycle, and keeps a
// busy scoreboard of outstanding destinations.
// Optional feature macro: WB_ROUND_ROBIN_EN (see wb_arb2).
module wb_commit_scheduler
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic [NREG-1:0]   busy,
    output logic              grant_b
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        accept;
    wb_commit_t  stage_q;
    wb_commit_t  stage_d;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Requests are masked during reset so nothing is accepted and the
    // round-robin pointer stays put.
    assign req = {b_valid, a_valid} & {2{~rst}};

    wb_arb2 u_arb (
`ifdef WB_ROUND_ROBIN_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (req),
        .gnt (gnt)
    );

    assign a_ready = gnt[WB_SRC_A];
    assign b_ready = gnt[WB_SRC_B];
    assign accept  = |gnt;

    // Commit-stage next state: load the winner, suppress writes to x0,
    // and keep addr/data/src stable through idle slots.
    always_comb begin
        stage_d    = stage_q;
        stage_d.en = 1'b0;
        if (accept) begin
            stage_d.src  = gnt[WB_SRC_B] ? WB_SRC_B : WB_SRC_A;
            stage_d.addr = gnt[WB_SRC_B] ? b_addr : a_addr;
            stage_d.data = gnt[WB_SRC_B] ? b_data : a_data;
            stage_d.en   = (stage_d.addr != '0);
        end
    end

    // Scoreboard next state: commit clears, reserve sets afterwards so a
    // same-address reserve keeps the bit; x0 never reads busy.
    always_comb begin
        busy_d = busy_q;
        if (stage_q.en) begin
            busy_d[stage_q.addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Commit stage and scoreboard registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            busy_q  <= '0;
        end else begin
            stage_q <= stage_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_write_en = stage_q.en;
    assign rf_w_addr   = stage_q.addr;
    assign rf_w_data   = stage_q.data;
    assign grant_b     = stage_q.src;
    assign busy        = busy_q;

endmodule
